// File: rtl/eth_loop_pkg.sv
// Shared definitions for the probe reflector: frame offsets, TX states and
// the FIFO entry layout. Building with ETH_LOOP_TS_EN widens each entry to
// carry an RX timestamp next to the sequence number.
package eth_loop_pkg;

    localparam int DST_OFS = 0;
    localparam int SRC_OFS = 6;
    localparam int ID_OFS  = 12;
    localparam int SEQ_OFS = 16;
    localparam int TS_OFS  = 20;
    localparam int TX_LEN  = 60;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

`ifdef ETH_LOOP_TS_EN
    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] ts;
    } fifo_entry_t;
`else
    typedef struct packed {
        logic [31:0] seq;
    } fifo_entry_t;
`endif

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/eth_loop_seq_fifo.sv
// Small synchronous FIFO holding pending reply entries. A push into a full
// FIFO is refused even if a pop happens in the same cycle.
module eth_loop_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/eth_loop_responder.sv
// Far-end reflector for latency probes. Parses RX frames, queues the
// sequence number of each accepted probe and sends a 60-byte reply per entry.
// Optional feature macro: ETH_LOOP_TS_EN (echo an RX cycle timestamp in
// reply bytes 20-23).
//
// TX FSM states:
//   state | meaning
//   IDLE  | no reply in flight; pops the FIFO when it holds an entry
//   SEND  | driving reply bytes 0..59, advancing on each handshake
module eth_loop_responder
    import eth_loop_pkg::*;
#(
    parameter logic [47:0] OWN_MAC    = 48'hDEAD_BEEF_0102,
    parameter logic [47:0] PEER_MAC   = 48'hDEAD_BEEF_0101,
    parameter logic [31:0] IDENTIFIER = 32'hCAFE_CAFE,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_s_axis_tdata,
    input  logic        i_s_axis_tkeep,
    input  logic        i_s_axis_tlast,
    input  logic        i_s_axis_tvalid,
    output logic [7:0]  o_m_axis_tdata,
    output logic        o_m_axis_tkeep,
    output logic        o_m_axis_tlast,
    output logic        o_m_axis_tvalid,
    input  logic        i_m_axis_tready,
    output logic [31:0] o_reply_count,
    output logic [31:0] o_drop_count
);

    localparam logic [4:0] RX_SAT   = 5'(TS_OFS);
    localparam logic [4:0] SEQ_LAST = 5'(TS_OFS - 1);
    localparam logic [5:0] TX_LAST  = 6'(TX_LEN - 1);

    // RX parser state
    logic [4:0]  r_rx_idx;
    logic        r_rx_bad;
    logic [31:0] r_rx_seq;
    logic        w_rx_chk;
    logic [7:0]  w_rx_exp;
    logic        w_rx_bad_now;
    logic [31:0] w_rx_seq_now;
    logic        w_push;

    // FIFO interface
    fifo_entry_t w_push_entry;
    fifo_entry_t w_fifo_rdata;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;

    // TX state
    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [5:0]  r_tx_idx;
    logic [5:0]  w_tx_idx_nxt;
    fifo_entry_t r_tx_entry;
    logic        w_reply_done;

    logic        w_unused;
    assign w_unused = i_s_axis_tkeep;

`ifdef ETH_LOOP_TS_EN
    logic [31:0] r_cycle;

    // Free-running cycle counter sampled on each accepted probe.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cycle <= '0;
        else       r_cycle <= r_cycle + 32'd1;
    end
`endif

    // Reply byte for a given index; bytes past the populated fields are zero.
    function automatic logic [7:0] tx_byte(input logic [5:0] idx, input fifo_entry_t ent);
        logic [31:0] k;
        logic [7:0]  b;
        k = 32'(idx);
        b = 8'h00;
        if (k < SRC_OFS)
            b = 8'(PEER_MAC >> (8 * (SRC_OFS - 1 - k)));
        else if (k < ID_OFS)
            b = 8'(OWN_MAC >> (8 * (ID_OFS - 1 - k)));
        else if (k < SEQ_OFS)
            b = 8'(IDENTIFIER >> (8 * (SEQ_OFS - 1 - k)));
        else if (k < TS_OFS)
            b = 8'(ent.seq >> (8 * (TS_OFS - 1 - k)));
`ifdef ETH_LOOP_TS_EN
        else if (k < TS_OFS + 4)
            b = 8'(ent.ts >> (8 * (TS_OFS + 3 - k)));
`endif
        return b;
    endfunction

    // Expected RX byte at the current index (destination MAC and identifier).
    always_comb begin
        w_rx_chk = 1'b0;
        w_rx_exp = 8'h00;
        if (r_rx_idx < 5'(SRC_OFS)) begin
            w_rx_chk = 1'b1;
            w_rx_exp = 8'(OWN_MAC >> (8 * (SRC_OFS - 1 - 32'(r_rx_idx))));
        end else if (r_rx_idx >= 5'(ID_OFS) && r_rx_idx < 5'(SEQ_OFS)) begin
            w_rx_chk = 1'b1;
            w_rx_exp = 8'(IDENTIFIER >> (8 * (SEQ_OFS - 1 - 32'(r_rx_idx))));
        end
    end

    // The current beat is folded in so a decision can be taken on the tlast beat itself.
    assign w_rx_bad_now = r_rx_bad ||
                          (w_rx_chk && (i_s_axis_tdata != w_rx_exp)) ||
                          (i_s_axis_tlast && (r_rx_idx < SEQ_LAST));
    assign w_rx_seq_now = (r_rx_idx == SEQ_LAST) ? {r_rx_seq[23:0], i_s_axis_tdata} : r_rx_seq;
    assign w_push       = i_s_axis_tvalid && i_s_axis_tlast && !w_rx_bad_now && i_enable;

`ifdef ETH_LOOP_TS_EN
    assign w_push_entry = '{seq: w_rx_seq_now, ts: r_cycle};
`else
    assign w_push_entry = '{seq: w_rx_seq_now};
`endif

    // RX parser: byte index, bad flag and big-endian sequence capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_idx <= '0;
            r_rx_bad <= 1'b0;
            r_rx_seq <= '0;
        end else if (i_s_axis_tvalid) begin
            if (i_s_axis_tlast) begin
                r_rx_idx <= '0;
                r_rx_bad <= 1'b0;
            end else begin
                if (r_rx_idx != RX_SAT) r_rx_idx <= r_rx_idx + 5'd1;
                r_rx_bad <= w_rx_bad_now;
            end
            if (r_rx_idx >= 5'(SEQ_OFS) && r_rx_idx < 5'(TS_OFS))
                r_rx_seq <= {r_rx_seq[23:0], i_s_axis_tdata};
        end
    end

    // Good probes that find the FIFO full are counted as drops.
    always_ff @(posedge i_clk) begin
        if (i_rst)                      o_drop_count <= '0;
        else if (w_push && w_fifo_full) o_drop_count <= o_drop_count + 32'd1;
    end

    eth_loop_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // TX state register, byte index, latched entry and reply counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_tx_idx      <= '0;
            r_tx_entry    <= '0;
            o_reply_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_idx <= w_tx_idx_nxt;
            if (w_pop)        r_tx_entry    <= w_fifo_rdata;
            if (w_reply_done) o_reply_count <= o_reply_count + 32'd1;
        end
    end

    // TX next-state and stream outputs; data depends only on registers so it holds under backpressure.
    always_comb begin
        w_state_nxt     = r_state;
        w_tx_idx_nxt    = r_tx_idx;
        w_pop           = 1'b0;
        w_reply_done    = 1'b0;
        o_m_axis_tvalid = 1'b0;
        o_m_axis_tkeep  = 1'b0;
        o_m_axis_tlast  = 1'b0;
        o_m_axis_tdata  = 8'h00;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_tx_idx_nxt = '0;
                    w_state_nxt  = SEND;
                end
            end
            SEND: begin
                o_m_axis_tvalid = 1'b1;
                o_m_axis_tkeep  = 1'b1;
                o_m_axis_tlast  = (r_tx_idx == TX_LAST);
                o_m_axis_tdata  = tx_byte(r_tx_idx, r_tx_entry);
                if (i_m_axis_tready) begin
                    if (r_tx_idx == TX_LAST) begin
                        w_reply_done = 1'b1;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_tx_idx_nxt = r_tx_idx + 6'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
